// File: rtl/riscv_data_mem.sv
// Data-memory responder for the RV32I load/store port: word RAM behind a valid/ready
// request/response handshake with wait states. Optional alignment faults: DMEM_MISALIGN_CHECK_EN.
module riscv_data_mem #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CW    = 4;
  localparam int unsigned LANES = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;

  logic              accept_c;
  logic              access_c;
  logic [AW-1:0]     idx_c;
  logic              oor_c;
  logic              misalign_c;
  logic              err_c;
  logic              wr_en_c;
  logic [LANES-1:0]  be_c;
  logic [XLEN-1:0]   lane_data_c;
  logic              req_ready_d;
  logic              rsp_valid_d;
  logic [XLEN-1:0]   rsp_rdata_d;
  logic              rsp_err_d;

  logic [XLEN-1:0]   mem [DEPTH_WORDS];

  assign accept_c = (state_q == S_IDLE) && req_valid && req_ready;
  // The access happens on the edge that leaves WAIT, so a reset during WAIT drops it.
  assign access_c = (state_q == S_WAIT) && (cnt_q == '0);
  assign idx_c    = addr_q[AW+1:2];
  assign oor_c    = (addr_q >> (AW + 2)) != '0;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign_c = ((size_q == 2'd1) && addr_q[0])
                   || ((size_q == 2'd2) && (addr_q[1:0] != 2'd0))
                   ||  (size_q == 2'd3);
`else
  assign misalign_c = 1'b0;
`endif

  assign err_c   = oor_c || misalign_c;
  assign wr_en_c = access_c && we_q && !err_c;

  // Lane steering; ignored low address bits fall away through the enable patterns.
  always_comb begin
    be_c        = '1;
    lane_data_c = wdata_q;
    case (size_q)
      2'd0: begin
        be_c        = LANES'(4'b0001 << addr_q[1:0]);
        lane_data_c = {LANES{wdata_q[7:0]}};
      end
      2'd1: begin
        be_c        = addr_q[1] ? LANES'(4'b1100) : LANES'(4'b0011);
        lane_data_c = {(LANES/2){wdata_q[15:0]}};
      end
      default: begin
        be_c        = '1;
        lane_data_c = wdata_q;
      end
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_WAIT;
          cnt_d   = CW'(WAIT_STATES);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_c;
          rsp_rdata_d = (!we_q && !err_c) ? mem[idx_c] : '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  // Captured request, held stable for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept_c) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // RAM contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (be_c[b]) mem[idx_c][8*b +: 8] <= lane_data_c[8*b +: 8];
      end
    end
  end

endmodule
